seg_tally_reader: RTL
=====================

SEG_TALLY_READER -- requirements
Module: seg_tally_reader

Interface
REQ-001 SHALL have parameter STABLE_LIMIT, default 4: cycles a decoded two-digit pattern must hold unchanged before commit (legal range 1..255).
REQ-002 SHALL have port i_Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_Reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_Segment1, input, 7 bits: tens (high nibble) digit segments, bit order {G,F,E,D,C,B,A}.
REQ-005 SHALL have port i_Segment2, input, 7 bits: units (low nibble) digit segments, same bit order.
REQ-006 SHALL have port o_Score, output, 8 bits: last committed score, {digit1,digit2}.
REQ-007 SHALL have port o_Score_Valid, output, 1 bit: high once any score has been committed since reset.
REQ-008 SHALL have port o_Update, output, 1 bit: one-cycle pulse on every commit.
REQ-009 SHALL have ports o_Inc, o_Dec, o_Clear, o_Jump, outputs, 1 bit each: one-cycle event pulses that are coincident with o_Update.
REQ-010 SHALL have port o_Error, output, 1 bit: one-cycle pulse when a stable pattern is not a legal hex glyph.

Function
REQ-011 SHALL decode each digit active-high: 0=ABCDEF, 1=BC, 2=ABDEG, 3=ABCDG, 4=BCFG, 5=ACDFG, 6=ACDEFG, 7=ABC, 8=ABCDEFG, 9=ABCDFG, A=ABCEFG, b=CDEFG, C=ADEF, d=BCDEG, E=ADEFG, F=AEFG; any other pattern is illegal.
REQ-012 SHALL register both segment inputs once (1-cycle sample stage) before comparison.
REQ-013 SHALL implement an FSM with states IDLE, SETTLE and COMMIT.
REQ-014 IDLE: when the sampled pattern differs from the last committed or rejected pattern, SHALL clear the stability counter and go to SETTLE.
REQ-015 SETTLE: if the pattern changes, SHALL restart the counter and stay in SETTLE; when the counter reaches STABLE_LIMIT, SHALL go to COMMIT.
REQ-016 COMMIT (one cycle): if both digits are legal, SHALL update o_Score, pulse o_Update, set o_Score_Valid and pulse exactly one event; otherwise SHALL pulse only o_Error with o_Score held. In both cases it SHALL record the pattern and return to IDLE.
REQ-017 Event classification with old=previous o_Score, new=decoded, 8-bit modulo arithmetic, in priority order: new==old+1 -> o_Inc; new==old-1 -> o_Dec; new==0 -> o_Clear; else o_Jump.
REQ-018 Wrap-around: old=FF to new=00 SHALL be o_Inc; old=00 to new=FF SHALL be o_Dec; old=01 to new=00 SHALL be o_Dec.
REQ-019 First commit after reset (o_Score_Valid low) SHALL pulse o_Update with no event pulse.
REQ-020 Latency: input stable from cycle t SHALL give o_Update at cycle t+STABLE_LIMIT+2.
REQ-021 A repeated identical pattern SHALL never re-commit; a glitch shorter than STABLE_LIMIT SHALL produce no output.

Reset
REQ-022 i_Reset SHALL force FSM=IDLE, counter=0, o_Score=00, o_Score_Valid=0, all pulses=0, and the recorded pattern to "none", so the first stable pattern is always evaluated.
REQ-023 Reset asserted mid-SETTLE or mid-COMMIT SHALL abort without any output pulse.

Configuration
REQ-024 SEG_INPUT_ACTIVE_LOW_EN defined: both segment buses SHALL be inverted at the sample stage (matches the active-low board display drive). Not defined: inputs SHALL be used as-is (active-high).

Structure
REQ-025 Package seg_tally_pkg SHALL hold the 16-entry glyph table, the FSM state typedef and the segment bit-index constants.
REQ-026 SHALL instantiate sub-module Segment_To_Binary twice; it is combinational (7-bit glyph in, 4-bit nibble out, legal flag out).

Verification
REQ-027 Reset, then hold 0x3F/0x06 ("01") for 10 cycles -> one o_Update with o_Score=01, no event, o_Score_Valid=1.
REQ-028 "01" then "02" stable -> o_Inc; then "01" -> o_Dec; then "00" -> o_Dec; then "FF" -> o_Dec.
REQ-029 "FF" then "00" -> o_Inc; "37" then "00" -> o_Clear; "37" then "5A" -> o_Jump.
REQ-030 Tens-digit glitch to 0x7F lasting STABLE_LIMIT-1 cycles between stable "42" holds -> no pulses, o_Score=42.
REQ-031 Tens-digit pattern 0x49 held -> single o_Error, o_Score unchanged; held for 100 more cycles -> no further pulse.
REQ-032 i_Reset asserted in SETTLE, with the same inputs held through and after release -> o_Score=00, no pulse during reset, and a first-commit o_Update with no event after release.

Source files
------------

// File: rtl/seg_tally_pkg.sv
// seg_tally_pkg -- shared definitions for the seven-segment score reader.
//   Segment bit indices within a glyph bus ({G,F,E,D,C,B,A}, bit 0 = A).
//   GLYPH_TBL: active-high segment pattern of each hex digit 0..F.
//   state_t / ST_*: FSM state encoding used by seg_tally_reader.
package seg_tally_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G + 1;

  localparam logic [SEG_W-1:0] GA = 7'(1) << SEG_A;
  localparam logic [SEG_W-1:0] GB = 7'(1) << SEG_B;
  localparam logic [SEG_W-1:0] GC = 7'(1) << SEG_C;
  localparam logic [SEG_W-1:0] GD = 7'(1) << SEG_D;
  localparam logic [SEG_W-1:0] GE = 7'(1) << SEG_E;
  localparam logic [SEG_W-1:0] GF = 7'(1) << SEG_F;
  localparam logic [SEG_W-1:0] GG = 7'(1) << SEG_G;

  localparam logic [SEG_W-1:0] GLYPH_TBL [16] = '{
    GA | GB | GC | GD | GE | GF,       // 0
    GB | GC,                           // 1
    GA | GB | GD | GE | GG,            // 2
    GA | GB | GC | GD | GG,            // 3
    GB | GC | GF | GG,                 // 4
    GA | GC | GD | GF | GG,            // 5
    GA | GC | GD | GE | GF | GG,       // 6
    GA | GB | GC,                      // 7
    GA | GB | GC | GD | GE | GF | GG,  // 8
    GA | GB | GC | GD | GF | GG,       // 9
    GA | GB | GC | GE | GF | GG,       // A
    GC | GD | GE | GF | GG,            // b
    GA | GD | GE | GF,                 // C
    GB | GC | GD | GE | GG,            // d
    GA | GD | GE | GF | GG,            // E
    GA | GE | GF | GG                  // F
  };

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_COMMIT = 2'd2;

endpackage

// File: rtl/Segment_To_Binary.sv
// Segment_To_Binary -- combinational seven-segment glyph decoder.
//   i_Segment : active-high segments {G,F,E,D,C,B,A}
//   o_Nibble  : decoded hex value (0 when illegal)
//   o_Legal   : 1 when i_Segment matches one of the 16 hex glyphs
module Segment_To_Binary
  import seg_tally_pkg::*;
(
  input  logic [SEG_W-1:0] i_Segment,
  output logic [3:0]       o_Nibble,
  output logic             o_Legal
);

  always_comb begin
    o_Nibble = 4'h0;
    o_Legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i_Segment == GLYPH_TBL[i]) begin
        o_Nibble = 4'(i);
        o_Legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_tally_reader.sv
// seg_tally_reader -- reads a two-digit seven-segment score display, waits
// for the pattern to settle, and reports committed scores plus change events.
//   i_Clk, i_Reset (sync, active-high)
//   i_Segment1/2   : tens / units glyphs {G,F,E,D,C,B,A}
//   o_Score        : last committed score {tens,units}
//   o_Score_Valid  : a score has been committed since reset
//   o_Update       : pulse on each commit; o_Inc/o_Dec/o_Clear/o_Jump coincide
//   o_Error        : pulse when a settled pattern is not a legal glyph pair
// Build option: SEG_INPUT_ACTIVE_LOW_EN inverts both segment buses at the
// sample stage for active-low display drive.
//
// state  | meaning
// IDLE   | waiting for a pattern different from the last recorded one
// SETTLE | counting cycles the candidate pattern stays unchanged
// COMMIT | one cycle: decode candidate, update score / flag error
module seg_tally_reader
  import seg_tally_pkg::*;
#(
  parameter int STABLE_LIMIT = 4
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [6:0] i_Segment1,
  input  logic [6:0] i_Segment2,
  output logic [7:0] o_Score,
  output logic       o_Score_Valid,
  output logic       o_Update,
  output logic       o_Inc,
  output logic       o_Dec,
  output logic       o_Clear,
  output logic       o_Jump,
  output logic       o_Error
);

  logic [SEG_W-1:0]   seg1_q, seg2_q;
  logic [2*SEG_W-1:0] cand_q, cand_d, rec_q, rec_d;
  logic               rec_vld_q, rec_vld_d;
  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         score_q, score_d;
  logic               valid_q, valid_d;
  logic               upd_d, inc_d, dec_d, clr_d, jmp_d, err_d;
  logic [2*SEG_W-1:0] pat;
  logic [3:0]         nib1, nib2;
  logic               legal1, legal2;
  logic [7:0]         new_score;

  // Decode the candidate rather than the live sample: the input may already
  // have moved on by the time the FSM sits in COMMIT.
  Segment_To_Binary u_dec_tens (
    .i_Segment (cand_q[2*SEG_W-1:SEG_W]),
    .o_Nibble  (nib1),
    .o_Legal   (legal1)
  );

  Segment_To_Binary u_dec_units (
    .i_Segment (cand_q[SEG_W-1:0]),
    .o_Nibble  (nib2),
    .o_Legal   (legal2)
  );

  assign pat       = {seg1_q, seg2_q};
  assign new_score = {nib1, nib2};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    rec_d     = rec_q;
    rec_vld_d = rec_vld_q;
    score_d   = score_q;
    valid_d   = valid_q;
    upd_d     = 1'b0;
    inc_d     = 1'b0;
    dec_d     = 1'b0;
    clr_d     = 1'b0;
    jmp_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rec_vld_q || pat != rec_q) begin
          cand_d  = pat;
          cnt_d   = 8'd0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (pat != cand_q) begin
          // Falling back to the recorded pattern ends the episode, so a
          // glitch never causes the old value to be committed a second time.
          if (rec_vld_q && pat == rec_q) begin
            state_d = ST_IDLE;
          end else begin
            cand_d = pat;
            cnt_d  = 8'd0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(STABLE_LIMIT)) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        rec_d     = cand_q;
        rec_vld_d = 1'b1;
        state_d   = ST_IDLE;
        if (legal1 && legal2) begin
          score_d = new_score;
          valid_d = 1'b1;
          upd_d   = 1'b1;
          if (valid_q) begin
            if (new_score == score_q + 8'd1)      inc_d = 1'b1;
            else if (new_score == score_q - 8'd1) dec_d = 1'b1;
            else if (new_score == 8'h00)          clr_d = 1'b1;
            else                                  jmp_d = 1'b1;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      seg1_q        <= '0;
      seg2_q        <= '0;
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      cand_q        <= '0;
      rec_q         <= '0;
      rec_vld_q     <= 1'b0;
      score_q       <= 8'h00;
      valid_q       <= 1'b0;
      o_Update      <= 1'b0;
      o_Inc         <= 1'b0;
      o_Dec         <= 1'b0;
      o_Clear       <= 1'b0;
      o_Jump        <= 1'b0;
      o_Error       <= 1'b0;
    end else begin
`ifdef SEG_INPUT_ACTIVE_LOW_EN
      seg1_q        <= ~i_Segment1;
      seg2_q        <= ~i_Segment2;
`else
      seg1_q        <= i_Segment1;
      seg2_q        <= i_Segment2;
`endif
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cand_q        <= cand_d;
      rec_q         <= rec_d;
      rec_vld_q     <= rec_vld_d;
      score_q       <= score_d;
      valid_q       <= valid_d;
      o_Update      <= upd_d;
      o_Inc         <= inc_d;
      o_Dec         <= dec_d;
      o_Clear       <= clr_d;
      o_Jump        <= jmp_d;
      o_Error       <= err_d;
    end
  end

  assign o_Score       = score_q;
  assign o_Score_Valid = valid_q;

endmodule
